instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_if.sv | 15 +
 rtl/instr_fetch.sv | 104 ++++++++++
 tb/tb_instr_fetch.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instr_fetch_if : instruction-memory request/response bundle          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface instr_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instr_fetch : two-state fetch/execute front end with retire counter  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  wire logic        clk,
  input  wire logic        rst,
  instr_fetch_if.master    imem,
  input  wire logic        stall,
  input  wire logic        resolve_valid,
  input  wire logic        branch,
  input  wire logic        jump,
  input  wire logic        zero,
  output logic [31:0]      ir,
  output logic [5:0]       op,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic             ir_valid,
  output logic [31:0]      retired
);

  typedef enum logic [0:0] {
    S_FETCH = 1'b0,
    S_EXEC  = 1'b1
  } state_t;

  state_t      r_state;
  logic [31:0] r_fetch_pc;
  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic        r_ir_valid;
  logic        r_imem_req;
  logic [31:0] r_retired;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_br_off;
  logic [31:0] w_next_pc;
  logic        w_retire;

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_br_off   = {{14{r_ir[15]}}, r_ir[15:0], 2'b00};
  assign w_retire   = (r_state == S_EXEC) && resolve_valid && !stall;

  // jump outranks a taken branch
  always_comb begin
    w_next_pc = w_pc_plus4;
    if (jump)
      w_next_pc = {w_pc_plus4[31:28], r_ir[25:0], 2'b00};
    else if (branch && zero)
      w_next_pc = w_pc_plus4 + w_br_off;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_FETCH;
      r_fetch_pc <= RESET_PC;
      r_pc       <= RESET_PC;
      r_ir       <= 32'h0;
      r_ir_valid <= 1'b0;
      r_imem_req <= 1'b1;
      r_retired  <= 32'h0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (imem.imem_ready) begin
            r_ir       <= imem.imem_rdata;
            r_pc       <= r_fetch_pc;
            r_ir_valid <= 1'b1;
            r_imem_req <= 1'b0;
            r_state    <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (w_retire) begin
            r_fetch_pc <= w_next_pc;
            r_ir_valid <= 1'b0;
            r_imem_req <= 1'b1;
            r_retired  <= r_retired + 32'd1;
            r_state    <= S_FETCH;
          end
        end
        default: begin
          r_state    <= S_FETCH;
          r_imem_req <= 1'b1;
          r_ir_valid <= 1'b0;
        end
      endcase
    end
  end

  assign imem.imem_req  = r_imem_req;
  assign imem.imem_addr = {r_fetch_pc[31:2], 2'b00};
  assign ir             = r_ir;
  assign op             = r_ir[31:26];
  assign pc             = r_pc;
  assign pc_plus4       = w_pc_plus4;
  assign ir_valid       = r_ir_valid;
  assign retired        = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_instr_fetch : vector table, corner sequences and random vs model  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        t_ready = 1'b0;
  logic [31:0] t_rdata = 32'h0;
  logic        t_stall = 1'b0;
  logic        t_resolve = 1'b0;
  logic        t_branch = 1'b0;
  logic        t_jump = 1'b0;
  logic        t_zero = 1'b0;

  logic        d_req   [3];
  logic [31:0] d_addr  [3];
  logic [31:0] d_ir    [3];
  logic [5:0]  d_op    [3];
  logic [31:0] d_pc    [3];
  logic [31:0] d_pp4   [3];
  logic        d_valid [3];
  logic [31:0] d_ret   [3];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  instr_fetch_if bus0 ();
  instr_fetch_if bus1 ();
  instr_fetch_if bus2 ();

  assign bus0.imem_ready = t_ready;
  assign bus0.imem_rdata = t_rdata;
  assign bus1.imem_ready = t_ready;
  assign bus1.imem_rdata = t_rdata;
  assign bus2.imem_ready = t_ready;
  assign bus2.imem_rdata = t_rdata;
  assign d_req[0]  = bus0.imem_req;
  assign d_addr[0] = bus0.imem_addr;
  assign d_req[1]  = bus1.imem_req;
  assign d_addr[1] = bus1.imem_addr;
  assign d_req[2]  = bus2.imem_req;
  assign d_addr[2] = bus2.imem_addr;

  instr_fetch #(.RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .rst(rst), .imem(bus0.master), .stall(t_stall),
    .resolve_valid(t_resolve), .branch(t_branch), .jump(t_jump), .zero(t_zero),
    .ir(d_ir[0]), .op(d_op[0]), .pc(d_pc[0]), .pc_plus4(d_pp4[0]),
    .ir_valid(d_valid[0]), .retired(d_ret[0]));

  instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
    .clk(clk), .rst(rst), .imem(bus1.master), .stall(t_stall),
    .resolve_valid(t_resolve), .branch(t_branch), .jump(t_jump), .zero(t_zero),
    .ir(d_ir[1]), .op(d_op[1]), .pc(d_pc[1]), .pc_plus4(d_pp4[1]),
    .ir_valid(d_valid[1]), .retired(d_ret[1]));

  instr_fetch #(.RESET_PC(32'h1000_0040)) u_dut_jmp (
    .clk(clk), .rst(rst), .imem(bus2.master), .stall(t_stall),
    .resolve_valid(t_resolve), .branch(t_branch), .jump(t_jump), .zero(t_zero),
    .ir(d_ir[2]), .op(d_op[2]), .pc(d_pc[2]), .pc_plus4(d_pp4[2]),
    .ir_valid(d_valid[2]), .retired(d_ret[2]));

  // Reference: one "has instruction" flag plus architectural registers per instance
  bit          m_has [3];
  logic [31:0] m_fpc [3];
  logic [31:0] m_pc  [3];
  logic [31:0] m_ir  [3];
  logic [31:0] m_ret [3];

  function automatic logic [31:0] rpc(int k);
    case (k)
      1:       return 32'hFFFF_FFFC;
      2:       return 32'h1000_0040;
      default: return 32'h0000_0000;
    endcase
  endfunction

  function automatic logic [31:0] ref_next(logic [31:0] p, logic [31:0] ins,
                                           logic b, logic j, logic z);
    logic [31:0] p4;
    logic signed [31:0] off;
    p4  = p + 32'd4;
    off = $signed(ins[15:0]);
    if (j) return {p4[31:28], ins[25:0], 2'b00};
    if (b && z) return p4 + ($unsigned(off) << 2);
    return p4;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_tick(int k);
    if (rst) begin
      m_has[k] = 1'b0;
      m_fpc[k] = rpc(k);
      m_pc[k]  = rpc(k);
      m_ir[k]  = 32'h0;
      m_ret[k] = 32'h0;
    end else if (!m_has[k]) begin
      if (t_ready) begin
        m_ir[k]  = t_rdata;
        m_pc[k]  = m_fpc[k];
        m_has[k] = 1'b1;
      end
    end else if (t_resolve && !t_stall) begin
      m_fpc[k] = ref_next(m_pc[k], m_ir[k], t_branch, t_jump, t_zero);
      m_has[k] = 1'b0;
      m_ret[k] = m_ret[k] + 32'd1;
    end
  endtask

  task automatic step();
    for (int k = 0; k < 3; k++) model_tick(k);
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("req[%0d]", k), {31'h0, d_req[k]}, {31'h0, !m_has[k]});
      if (!m_has[k]) check($sformatf("addr[%0d]", k), d_addr[k], m_fpc[k]);
      check($sformatf("valid[%0d]", k), {31'h0, d_valid[k]}, {31'h0, m_has[k]});
      check($sformatf("ir[%0d]", k), d_ir[k], m_ir[k]);
      check($sformatf("op[%0d]", k), {26'h0, d_op[k]}, {26'h0, m_ir[k][31:26]});
      check($sformatf("pc[%0d]", k), d_pc[k], m_pc[k]);
      check($sformatf("pc4[%0d]", k), d_pp4[k], m_pc[k] + 32'd4);
      check($sformatf("ret[%0d]", k), d_ret[k], m_ret[k]);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic do_instr(logic [31:0] rd, int lat, int stalls, logic b, logic j, logic z);
    t_ready = 1'b0;
    t_resolve = 1'b0;
    repeat (lat) step();
    t_ready = 1'b1;
    t_rdata = rd;
    step();
    t_ready = 1'b0;
    t_rdata = $urandom;
    t_branch = b;
    t_jump = j;
    t_zero = z;
    t_resolve = 1'b1;
    t_stall = 1'b1;
    repeat (stalls) step();
    t_stall = 1'b0;
    step();
    t_resolve = 1'b0;
    t_branch = 1'b0;
    t_jump = 1'b0;
    t_zero = 1'b0;
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic        br;
    logic        jp;
    logic        z;
    logic [31:0] exp_addr;
    logic [31:0] exp_ret;
  } vec_t;

  vec_t tbl [8];

  initial begin
    logic [31:0] ret0;
    tbl[0] = '{32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0004, 32'd1};
    tbl[1] = '{32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0008, 32'd2};
    tbl[2] = '{32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_000C, 32'd3};
    tbl[3] = '{32'h0800_0040, 1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'd4};
    tbl[4] = '{32'h1000_FFFE, 1'b1, 1'b0, 1'b1, 32'h0000_00FC, 32'd5};
    tbl[5] = '{32'h1000_0001, 1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'd6};
    tbl[6] = '{32'h1000_FFFE, 1'b1, 1'b0, 1'b0, 32'h0000_0104, 32'd7};
    tbl[7] = '{32'h0800_0080, 1'b1, 1'b1, 1'b1, 32'h0000_0200, 32'd8};

    do_reset();
    check("rst_addr", d_addr[0], 32'h0);
    check("rst_req", {31'h0, d_req[0]}, 32'h1);
    check("rst_ret", d_ret[0], 32'h0);
    check("rst_ir", d_ir[0], 32'h0);

    for (int i = 0; i < 8; i++) begin
      do_instr(tbl[i].rdata, i % 2, 0, tbl[i].br, tbl[i].jp, tbl[i].z);
      check($sformatf("tbl%0d_addr", i), d_addr[0], tbl[i].exp_addr);
      check($sformatf("tbl%0d_ret", i), d_ret[0], tbl[i].exp_ret);
    end

    // 3-cycle memory latency, then 2 stalled resolve cycles
    ret0 = d_ret[0];
    t_ready = 1'b0;
    repeat (3) begin
      step();
      check("lat_addr", d_addr[0], 32'h0000_0200);
    end
    t_ready = 1'b1;
    t_rdata = 32'hDEAD_BEEF;
    step();
    t_ready = 1'b0;
    t_resolve = 1'b1;
    t_stall = 1'b1;
    repeat (2) begin
      step();
      check("stall_ir", d_ir[0], 32'hDEAD_BEEF);
      check("stall_ret", d_ret[0], ret0);
    end
    t_stall = 1'b0;
    step();
    check("stall_retire", d_ret[0], ret0 + 32'd1);
    step();
    check("fetch_no_retire", d_ret[0], ret0 + 32'd1);
    t_resolve = 1'b0;

    // reset while an instruction is resolving
    t_ready = 1'b1;
    step();
    t_ready = 1'b0;
    t_resolve = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    t_resolve = 1'b0;
    check("rstx_valid", {31'h0, d_valid[0]}, 32'h0);
    check("rstx_ret", d_ret[0], 32'h0);
    check("rstx_addr", d_addr[0], 32'h0);

    // reset overrides a ready fetch
    t_ready = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    t_ready = 1'b0;
    check("rstf_valid", {31'h0, d_valid[0]}, 32'h0);
    check("wrap_rst_addr", d_addr[1], 32'hFFFF_FFFC);

    do_instr(32'h0800_0010, 0, 0, 1'b1, 1'b1, 1'b1);
    check("jmp_prio_addr", d_addr[2], 32'h1000_0040);
    do_reset();
    do_instr(32'h0000_0000, 0, 0, 1'b0, 1'b0, 1'b0);
    check("wrap_addr", d_addr[1], 32'h0000_0000);

    for (int c = 0; c < 600; c++) begin
      rst       = ($urandom_range(0, 59) == 0);
      t_ready   = $urandom_range(0, 1) == 1;
      t_rdata   = $urandom;
      t_stall   = $urandom_range(0, 3) == 0;
      t_resolve = $urandom_range(0, 2) != 0;
      t_branch  = $urandom_range(0, 1) == 1;
      t_jump    = $urandom_range(0, 3) == 0;
      t_zero    = $urandom_range(0, 1) == 1;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
